// File: rtl/sensor_matrix_scanner.sv
// Row-by-row scanner and frame debouncer for the 8x8 reed-switch checkers board.
// Define SENSOR_CHANGE_IRQ_EN to drive change_pulse/change_mask; otherwise both read 0.
`timescale 1ns/1ps

module sensor_matrix_scanner #(
    parameter int SETTLE_CYCLES  = 64,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int CNT_W          = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        scan_en,
    input  logic [7:0]  col_in,
    output logic [7:0]  row_sel,
    output logic [31:0] sensor_board,
    output logic        board_valid,
    output logic        frame_done,
    output logic        change_pulse,
    output logic [31:0] change_mask
);

    localparam int MW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam logic [MW-1:0]    MATCH_MAX   = MW'(DEBOUNCE_SCANS - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        COMMIT
    } state_t;

    state_t            state;
    logic [2:0]        row;
    logic [CNT_W-1:0]  cnt;
    logic [7:0]        col_meta;
    logic [7:0]        col_sync;
    logic [31:0]       raw_frame;
    logic [31:0]       prev_raw;
    logic [MW-1:0]     match_cnt;
    logic [MW-1:0]     match_next;
    logic [3:0]        row_bits;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col_meta <= 8'h00;
            col_sync <= 8'h00;
        end else begin
            col_meta <= col_in;
            col_sync <= col_meta;
        end
    end

    // Dark squares sit on odd columns in even rows and even columns in odd rows.
    always_comb begin
        row_bits = {col_sync[7], col_sync[5], col_sync[3], col_sync[1]};
        if (row[0]) begin
            row_bits = {col_sync[6], col_sync[4], col_sync[2], col_sync[0]};
        end
    end

    always_comb begin
        match_next = '0;
        if (raw_frame == prev_raw) begin
            match_next = (match_cnt == MATCH_MAX) ? MATCH_MAX : match_cnt + MW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            row          <= 3'd0;
            cnt          <= '0;
            row_sel      <= 8'h00;
            sensor_board <= 32'h0;
            board_valid  <= 1'b0;
            frame_done   <= 1'b0;
            raw_frame    <= 32'h0;
            prev_raw     <= 32'h0;
            match_cnt    <= '0;
`ifdef SENSOR_CHANGE_IRQ_EN
            change_pulse <= 1'b0;
            change_mask  <= 32'h0;
`endif
        end else begin
            frame_done <= 1'b0;
`ifdef SENSOR_CHANGE_IRQ_EN
            change_pulse <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    row_sel <= 8'h00;
                    if (scan_en) begin
                        state   <= SETTLE;
                        row     <= 3'd0;
                        cnt     <= '0;
                        row_sel <= 8'h01;
                    end
                end

                SETTLE: begin
                    if (!scan_en) begin
                        state   <= IDLE;
                        row_sel <= 8'h00;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == SETTLE_LAST) begin
                            state <= SAMPLE;
                        end
                    end
                end

                // An abort here leaves raw_frame untouched.
                SAMPLE: begin
                    if (!scan_en) begin
                        state   <= IDLE;
                        row_sel <= 8'h00;
                    end else begin
                        raw_frame[{row, 2'b00} +: 4] <= row_bits;
                        if (row == 3'd7) begin
                            state      <= COMMIT;
                            row_sel    <= 8'h00;
                            frame_done <= 1'b1;
                        end else begin
                            state   <= SETTLE;
                            row     <= row + 3'd1;
                            cnt     <= '0;
                            row_sel <= row_sel << 1;
                        end
                    end
                end

                COMMIT: begin
                    match_cnt <= match_next;
                    prev_raw  <= raw_frame;
                    if (match_next == MATCH_MAX) begin
                        sensor_board <= raw_frame;
                        board_valid  <= 1'b1;
`ifdef SENSOR_CHANGE_IRQ_EN
                        if (raw_frame != sensor_board) begin
                            change_mask  <= raw_frame ^ sensor_board;
                            change_pulse <= 1'b1;
                        end
`endif
                    end
                    if (scan_en) begin
                        state   <= SETTLE;
                        row     <= 3'd0;
                        cnt     <= '0;
                        row_sel <= 8'h01;
                    end else begin
                        state   <= IDLE;
                        row_sel <= 8'h00;
                    end
                end

                default: begin
                    state   <= IDLE;
                    row_sel <= 8'h00;
                end
            endcase
        end
    end

`ifndef SENSOR_CHANGE_IRQ_EN
    assign change_pulse = 1'b0;
    assign change_mask  = 32'h0;
`endif

endmodule

// File: tb/tb_sensor_matrix_scanner.sv
// Scoreboard bench for sensor_matrix_scanner: a board model drives col_in from row_sel,
// each frame pushes its expected commit result and a monitor checks it after frame_done.
`timescale 1ns/1ps

module tb_sensor_matrix_scanner;

    logic        clock;
    logic        reset;
    logic        scan_en;
    logic [7:0]  col_in;
    logic [7:0]  row_sel;
    logic [31:0] sensor_board;
    logic        board_valid;
    logic        frame_done;
    logic        change_pulse;
    logic [31:0] change_mask;

    int checks = 0;
    int errors = 0;

`ifdef SENSOR_CHANGE_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] board;
        logic        valid;
        logic        pulse;
        logic [31:0] mask;
    } exp_t;

    exp_t expq[$];
    logic [7:0] phys [8];

    sensor_matrix_scanner #(
        .SETTLE_CYCLES (4),
        .DEBOUNCE_SCANS(3),
        .CNT_W         (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .scan_en     (scan_en),
        .col_in      (col_in),
        .row_sel     (row_sel),
        .sensor_board(sensor_board),
        .board_valid (board_valid),
        .frame_done  (frame_done),
        .change_pulse(change_pulse),
        .change_mask (change_mask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Physical reed-switch matrix: the driven row's switches appear on the column lines.
    always_comb begin
        col_in = 8'h00;
        for (int r = 0; r < 8; r++) begin
            if (row_sel[r]) col_in = col_in | phys[r];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic setBoard(input logic [31:0] bits, input logic noise);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (((r + c) % 2) == 1) phys[r][c] = bits[4 * r + c / 2];
                else                    phys[r][c] = noise;
            end
        end
    endtask

    task automatic waitFrame();
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clock);
            if (frame_done) seen = 1'b1;
        end
        checkOutput("frame_done_seen", 32'(seen), 32'd1);
    endtask

    // Drives one frame's board, queues its expected commit, then waits for its frame_done.
    task automatic applyStimulus(input logic [31:0] bits, input logic noise, input bit sweep,
                                 input logic [31:0] eb, input logic ev, input logic ep,
                                 input logic [31:0] em);
        setBoard(bits, noise);
        expq.push_back('{board: eb, valid: ev, pulse: ep, mask: em});
        scan_en = 1'b1;
        if (sweep) begin
            for (int k = 0; k < 41; k++) begin
                logic [7:0] er;
                @(negedge clock);
                er = (k == 40) ? 8'h00 : (8'h01 << (k / 5));
                checkOutput($sformatf("row_sel_k%0d", k), 32'(row_sel), 32'(er));
                checkOutput($sformatf("frame_done_k%0d", k), 32'(frame_done), 32'(k == 40));
            end
        end else begin
            waitFrame();
        end
    endtask

    // Monitor: the commit result is visible the cycle after frame_done.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset && frame_done) begin
                @(negedge clock);
                if (expq.size() == 0) begin
                    checkOutput("unexpected_frame_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    checkOutput("sensor_board", sensor_board, e.board);
                    checkOutput("board_valid", 32'(board_valid), 32'(e.valid));
                    checkOutput("change_pulse", 32'(change_pulse), 32'(e.pulse));
                    checkOutput("change_mask", change_mask, e.mask);
                end
            end
        end
    end

    initial begin
        bit found;
        bit fd_seen;
        reset   = 1'b1;
        scan_en = 1'b0;
        setBoard(32'h0, 1'b0);
        repeat (3) @(negedge clock);
        checkOutput("reset_row_sel", 32'(row_sel), 32'h0);
        checkOutput("reset_board", sensor_board, 32'h0);
        checkOutput("reset_valid", 32'(board_valid), 32'h0);
        checkOutput("reset_frame_done", 32'(frame_done), 32'h0);
        checkOutput("reset_change_mask", change_mask, 32'h0);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("idle_row_sel", 32'(row_sel), 32'h0);

        // Debounce: three identical frames before the first commit.
        applyStimulus(32'h00000FFF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        applyStimulus(32'h00000FFF, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        applyStimulus(32'h00000FFF, 1'b1, 1'b0, 32'h00000FFF, 1'b1, IRQ, IRQ ? 32'h00000FFF : 32'h0);
        applyStimulus(32'h00000FFF, 1'b0, 1'b0, 32'h00000FFF, 1'b1, 1'b0, IRQ ? 32'h00000FFF : 32'h0);
        // Piece moves from square 0 to square 12.
        applyStimulus(32'h00001FFE, 1'b0, 1'b0, 32'h00000FFF, 1'b1, 1'b0, IRQ ? 32'h00000FFF : 32'h0);
        applyStimulus(32'h00001FFE, 1'b0, 1'b0, 32'h00000FFF, 1'b1, 1'b0, IRQ ? 32'h00000FFF : 32'h0);
        applyStimulus(32'h00001FFE, 1'b0, 1'b0, 32'h00001FFE, 1'b1, IRQ, IRQ ? 32'h00001001 : 32'h0);

        // Abort while row 3 is driven.
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clock);
            if (row_sel == 8'h08) found = 1'b1;
        end
        checkOutput("abort_row3_reached", 32'(found), 32'd1);
        scan_en = 1'b0;
        @(negedge clock);
        checkOutput("abort_row_sel", 32'(row_sel), 32'h0);
        fd_seen = 1'b0;
        repeat (30) begin
            @(negedge clock);
            if (frame_done) fd_seen = 1'b1;
        end
        checkOutput("abort_no_frame_done", 32'(fd_seen), 32'd0);
        checkOutput("abort_board_kept", sensor_board, 32'h00001FFE);

        // Restart at row 0, then toggle square 12 each frame: no commit may happen.
        setBoard(32'h00000FFE, 1'b0);
        expq.push_back('{board: 32'h00001FFE, valid: 1'b1, pulse: 1'b0, mask: IRQ ? 32'h00001001 : 32'h0});
        scan_en = 1'b1;
        @(negedge clock);
        checkOutput("restart_row_sel", 32'(row_sel), 32'h01);
        waitFrame();
        applyStimulus(32'h00001FFE, 1'b0, 1'b0, 32'h00001FFE, 1'b1, 1'b0, IRQ ? 32'h00001001 : 32'h0);
        applyStimulus(32'h00000FFE, 1'b0, 1'b0, 32'h00001FFE, 1'b1, 1'b0, IRQ ? 32'h00001001 : 32'h0);
        applyStimulus(32'h00000FFE, 1'b0, 1'b0, 32'h00001FFE, 1'b1, 1'b0, IRQ ? 32'h00001001 : 32'h0);
        applyStimulus(32'h00000FFE, 1'b0, 1'b0, 32'h00000FFE, 1'b1, IRQ, IRQ ? 32'h00001000 : 32'h0);

        // Asynchronous reset in the middle of a row's settle time.
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clock);
            if (row_sel == 8'h04) found = 1'b1;
        end
        checkOutput("mid_settle_reached", 32'(found), 32'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_row_sel", 32'(row_sel), 32'h0);
        checkOutput("async_reset_board", sensor_board, 32'h0);
        checkOutput("async_reset_valid", 32'(board_valid), 32'h0);
        checkOutput("async_reset_mask", change_mask, 32'h0);
        scan_en = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("scoreboard_drained", 32'(expq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sensor_matrix_scanner.md
Name: sensor_matrix_scanner

Overview:
- Scans the 8x8 reed-switch matrix under the checkers board, one row at a time, and debounces complete frames.
- Produces the 32-bit dark-square occupancy bitmap that feeds the memory manager's sensor-board input, which the CPU reads at address 0x1001.
- Sits between the board I/O pins and the memory manager; all logic is in the CPU clock domain.

Parameters:
- SETTLE_CYCLES, 64, cycles each row is driven before its columns are sampled; must be >= 3 to cover the 2-flop column synchronizer.
- DEBOUNCE_SCANS, 4, number of consecutive identical raw frames required before sensor_board updates; must be >= 1.
- CNT_W, 8, width of the settle counter; must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- scan_en  in  1  level-sensitive enable for scanning.
- col_in  in  8  raw column sense lines, active-high (1 = piece present), asynchronous to clock.
- row_sel  out  8  one-hot active-high row drive; 8'h00 when not scanning.
- sensor_board  out  32  debounced occupancy bitmap.
- board_valid  out  1  high from the first commit onward.
- frame_done  out  1  one-cycle pulse at every completed frame.
- change_pulse  out  1  see Optional Feature.
- change_mask  out  32  see Optional Feature.

Behaviour:
- Reset (asynchronous, takes effect immediately with no clock edge):
  - State machine goes to IDLE; row index = 0; settle counter = 0.
  - row_sel = 0, sensor_board = 0, board_valid = 0, frame_done = 0, change_pulse = 0, change_mask = 0.
  - raw_frame = 0, prev_raw = 0, match_cnt = 0.
- col_in passes through a 2-flop synchronizer before any use.
- Square mapping: row r, column c is a dark square when (r+c) is odd. Its bit index is 4*r + (c>>1).
  - Row 0 uses columns 1, 3, 5, 7 (bits 0-3).
  - Row 1 uses columns 0, 2, 4, 6 (bits 4-7).
  - Light-square columns are ignored.
- IDLE: row_sel = 0. When scan_en = 1, go to SETTLE with row = 0 and counter = 0.
- SETTLE: row_sel = 1 << row; the counter increments each cycle. After SETTLE_CYCLES cycles in SETTLE, go to SAMPLE.
- SAMPLE (1 cycle, row_sel still driven):
  - Write the 4 synchronized dark-square bits of this row into raw_frame[4r+3:4r].
  - If row < 7: increment row, clear the counter, go to SETTLE.
  - If row = 7: go to COMMIT.
- COMMIT (1 cycle, row_sel = 0):
  - If raw_frame == prev_raw: match_cnt = min(match_cnt+1, DEBOUNCE_SCANS-1); otherwise match_cnt = 0.
  - prev_raw <= raw_frame.
  - If the new match_cnt == DEBOUNCE_SCANS-1: sensor_board <= raw_frame and board_valid <= 1.
  - frame_done = 1 for this cycle only.
  - Next state: if scan_en = 1, SETTLE with row = 0; otherwise IDLE.
- Frame period: 8*(SETTLE_CYCLES+1) + 1 cycles.
- With DEBOUNCE_SCANS = 1, every frame commits.
- scan_en = 0 while in SETTLE or SAMPLE (abort):
  - Next cycle enters IDLE with row_sel = 0.
  - No commit and no frame_done.
  - raw_frame, prev_raw, match_cnt and sensor_board are unchanged.
- The first frame after reset compares against prev_raw = 0, so an empty board counts as one match on frame 1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: SENSOR_CHANGE_IRQ_EN.
- When defined, on any COMMIT that actually updates sensor_board to a different value:
  - change_mask <= old sensor_board XOR new sensor_board; it is held until the next such update.
  - change_pulse = 1 for that cycle only.
  - A commit that leaves the value unchanged produces no pulse and leaves change_mask as it was.
- When not defined, change_pulse and change_mask are tied to 0; the ports remain so the interface is identical either way.

Test Plan (SETTLE_CYCLES=4, DEBOUNCE_SCANS=3, frame = 41 cycles):
- Reset, then scan_en=1 with col_in static for pieces on rows 0-2 -> sensor_board = 0x00000FFF after the 3rd frame_done (stays 0 after the 1st and 2nd); board_valid rises in the same cycle.
- Free-running scan -> row_sel steps 01, 02, 04 ... 80, each held 5 cycles, then 00 for 1 cycle while frame_done = 1; the pattern repeats every 41 cycles.
- Square bit 12 (row 3, column 0) toggles every frame, rest stable -> sensor_board never changes from its prior value; match_cnt stays 0.
- scan_en dropped while row_sel = 8'h08 -> row_sel = 0 next cycle, no frame_done; re-enable restarts at row_sel = 8'h01.
- Assert reset asynchronously mid-SETTLE -> row_sel, sensor_board and board_valid read 0 before the next clock edge.
- SENSOR_CHANGE_IRQ_EN defined: stable board moves 0x00000FFF -> 0x00001FFE -> after 3 stable frames, change_pulse = 1 for one cycle and change_mask = 0x00001001.
